// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types, constants and helpers for the serial front
//                ends (bit_serializer and its hold slot).
//                - SER_WIDTH_DEFAULT : default parallel word width
//                - SER_WIDTH_MAX     : widest legal word
//                - ser_cnt_t         : bit counter wide enough for 0..WIDTH
//                - ser_state_e       : IDLE/SHIFT view derived from the counter
//                - head_index()      : index of the bit that leaves first
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;
  localparam int SER_WIDTH_MAX     = 32;

  // Sized for the widest legal word so every instance can share one type;
  // this holds any count in 0..WIDTH for WIDTH up to SER_WIDTH_MAX.
  typedef logic [$clog2(SER_WIDTH_MAX + 1)-1:0] ser_cnt_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  function automatic int head_index(input int width, input bit msb_first);
    return msb_first ? (width - 1) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_hold_slot.sv
`default_nettype none
// ============================================================================
//  Module      : ser_hold_slot
//  Description : One-entry holding register for serial front ends. A word is
//                parked here while the shifter is still busy with the
//                previous one, and handed over when the shifter drains.
//  Ports       : clk      - clock
//                reset    - synchronous, active-high reset
//                load_i   - capture data_i and mark the slot full
//                data_i   - word to park
//                drain_i  - the parked word has been taken; mark empty
//                data_o   - parked word
//                full_o   - slot holds a word
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_hold_slot
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             drain_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // A simultaneous load and drain keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Parallel-to-serial front end for a serial pattern detector.
//                Accepts WIDTH-bit words on a valid/ready handshake and
//                shifts them out one bit per enabled clock. A one-entry hold
//                slot lets consecutive words stream with no idle gap; with
//                nothing in flight the output carries IDLE_BIT.
//  Ports       : clk       - clock
//                reset     - synchronous, active-high reset
//                enable    - shift enable; 0 freezes the shifter
//                in_data   - parallel word
//                in_valid  - in_data is valid
//                in_ready  - word accepted when in_valid && in_ready
//                ser_bit   - serial bit (IDLE_BIT when ser_valid=0)
//                ser_valid - ser_bit carries payload
//                ser_last  - ser_bit is the final bit of the word
//                busy      - a word is shifting or parked
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int       C_HEAD     = head_index(WIDTH, MSB_FIRST);
  localparam ser_cnt_t C_CNT_FULL = ser_cnt_t'(WIDTH);
  localparam ser_cnt_t C_CNT_ONE  = ser_cnt_t'(1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  ser_cnt_t         cnt_q, cnt_d;

  ser_state_e       w_state;
  logic [WIDTH-1:0] w_shifted;
  logic             w_head;
  logic             w_accept;
  logic             w_hold_load;
  logic             w_hold_drain;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_hold_full;

  // --------------------------------------------------------------------------
  // Hold slot
  // --------------------------------------------------------------------------
  ser_hold_slot #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_hold_load),
    .data_i  (in_data),
    .drain_i (w_hold_drain),
    .data_o  (w_hold_data),
    .full_o  (w_hold_full)
  );

  // --------------------------------------------------------------------------
  // Shift direction: the register always moves toward the head bit and the
  // vacated position fills with 0.
  // --------------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign w_head  = shreg_q[C_HEAD];
  assign w_state = (cnt_q != '0) ? ST_SHIFT : ST_IDLE;

  // Reset forces in_ready low so nothing is accepted on the reset edge.
  assign in_ready  = !w_hold_full && !reset;
  assign w_accept  = in_valid && in_ready;

  assign ser_valid = (w_state == ST_SHIFT) && enable;
  assign ser_bit   = ser_valid ? w_head : IDLE_BIT;
  assign ser_last  = ser_valid && (cnt_q == C_CNT_ONE);
  assign busy      = (w_state == ST_SHIFT) || w_hold_full;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    w_hold_load  = 1'b0;
    w_hold_drain = 1'b0;
    unique case (w_state)
      ST_IDLE: begin
        // Loads even with enable low; output stays idle until enabled.
        if (w_accept) begin
          shreg_d = in_data;
          cnt_d   = C_CNT_FULL;
        end
      end
      ST_SHIFT: begin
        if (enable && (cnt_q == C_CNT_ONE)) begin
          // Last bit leaves on this edge: chain straight into the next word.
          // A parked word has priority; in_ready is low while it is parked,
          // so the two branches never compete for the same edge.
          if (w_hold_full) begin
            shreg_d      = w_hold_data;
            cnt_d        = C_CNT_FULL;
            w_hold_drain = 1'b1;
          end else if (w_accept) begin
            shreg_d = in_data;
            cnt_d   = C_CNT_FULL;
          end else begin
            cnt_d = '0;
          end
        end else begin
          if (enable) begin
            shreg_d = w_shifted;
            cnt_d   = cnt_q - C_CNT_ONE;
          end
          // Mid-word acceptance parks the word, independent of enable.
          w_hold_load = w_accept;
        end
      end
      default: begin
        shreg_d = shreg_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Self-checking bench for bit_serializer. Two instances
//                (MSB-first and LSB-first) share one stimulus stream; both
//                are compared every cycle against a word-queue reference
//                model, and directed sequences add hand-computed checks.
//                A small behavioural "101" detector stands in for the
//                downstream pattern-detector FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         enable;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [1:0]   rdy, sbit, sval, slast, sbusy;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[0]), .ser_bit(sbit[0]),
    .ser_valid(sval[0]), .ser_last(slast[0]), .busy(sbusy[0])
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[1]), .ser_bit(sbit[1]),
    .ser_valid(sval[1]), .ser_last(slast[1]), .busy(sbusy[1])
  );

  // Behavioural stand-in for the downstream detector: registered pulse when
  // the last three sampled bits are 1,0,1.
  logic [1:0] hist;
  logic       det;
  always @(posedge clk) begin
    if (reset) begin
      hist <= 2'b00;
      det  <= 1'b0;
    end else begin
      hist <= {hist[0], sbit[0]};
      det  <= ({hist, sbit[0]} == 3'b101);
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: a queue of up to two words (in flight + parked) and the
  // number of bits of the front word already sent.
  logic [W-1:0] mword [2][2];
  int           mcnt  [2];
  int           mpos  [2];

  // Values sampled from the DUTs in the current cycle.
  logic [1:0] s_bit, s_val, s_last, s_rdy, s_busy;
  logic       s_det;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         en;
    logic         eb, ev, el, er, ey;
  } vec_t;
  vec_t tab [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic e, input logic v, input logic [W-1:0] d);
    reset    = r;
    enable   = e;
    in_valid = v;
    in_data  = d;
  endtask

  // One clock: sample and model-check at the falling edge, advance the model
  // at the rising edge, return 1ns later so the caller can drive new inputs.
  task automatic tick();
    logic [1:0] ev, eb, el, er, ey;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int           idx;
      logic [W-1:0] w;
      ev[k] = (mcnt[k] > 0) && enable;
      idx   = (k == 0) ? (W - 1 - mpos[k]) : mpos[k];
      w     = mword[k][0];
      eb[k] = ev[k] ? w[idx] : 1'b0;
      el[k] = ev[k] && (mpos[k] == W - 1);
      er[k] = (mcnt[k] < 2) && !reset;
      ey[k] = (mcnt[k] > 0);
    end
    s_bit = sbit; s_val = sval; s_last = slast; s_rdy = rdy; s_busy = sbusy;
    s_det = det;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_ser_bit[%0d] t=%0t", k, $time),   {31'd0, sbit[k]},  {31'd0, eb[k]});
      chk($sformatf("model_ser_valid[%0d] t=%0t", k, $time), {31'd0, sval[k]},  {31'd0, ev[k]});
      chk($sformatf("model_ser_last[%0d] t=%0t", k, $time),  {31'd0, slast[k]}, {31'd0, el[k]});
      chk($sformatf("model_in_ready[%0d] t=%0t", k, $time),  {31'd0, rdy[k]},   {31'd0, er[k]});
      chk($sformatf("model_busy[%0d] t=%0t", k, $time),      {31'd0, sbusy[k]}, {31'd0, ey[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mcnt[k] = 0;
        mpos[k] = 0;
      end else begin
        if (ev[k]) begin
          mpos[k]++;
          if (mpos[k] == W) begin
            mword[k][0] = mword[k][1];
            mcnt[k]--;
            mpos[k] = 0;
          end
        end
        if (in_valid && er[k]) begin
          mword[k][mcnt[k]] = in_data;
          mcnt[k]++;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0]  a5_bits;
    logic [15:0] bb;
    logic [7:0]  f0_bits;
    logic [7:0]  w81;
    int          nval, lastc, j, pulses;
    logic        en;

    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      mpos[k] = 0;
      mword[k][0] = '0;
      mword[k][1] = '0;
    end

    // Bring both DUTs out of power-up before any comparison.
    drive(1'b1, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1;

    // ---------------- Reset state ----------------
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    tick();
    chk("reset_in_ready", {31'd0, s_rdy[0]}, 32'd0);
    chk("reset_busy",     {31'd0, s_busy[0]}, 32'd0);
    chk("reset_ser_valid",{31'd0, s_val[0]}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    chk("post_reset_in_ready", {31'd0, s_rdy[0]}, 32'd1);
    chk("post_reset_ser_bit",  {31'd0, s_bit[0]}, 32'd0);

    // ---------------- Table: single word 8'hA5, MSB first ----------------
    a5_bits = 8'b1010_0101;
    tab[0] = '{v:1'b1, d:8'hA5, en:1'b1, eb:1'b0, ev:1'b0, el:1'b0, er:1'b1, ey:1'b0};
    for (int i = 1; i <= 8; i++)
      tab[i] = '{v:1'b0, d:8'h00, en:1'b1, eb:a5_bits[8-i], ev:1'b1,
                 el:(i == 8), er:1'b1, ey:1'b1};
    tab[9] = '{v:1'b0, d:8'h00, en:1'b1, eb:1'b0, ev:1'b0, el:1'b0, er:1'b1, ey:1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, tab[i].en, tab[i].v, tab[i].d);
      tick();
      chk($sformatf("tab_ser_bit c%0d", i),   {31'd0, s_bit[0]},  {31'd0, tab[i].eb});
      chk($sformatf("tab_ser_valid c%0d", i), {31'd0, s_val[0]},  {31'd0, tab[i].ev});
      chk($sformatf("tab_ser_last c%0d", i),  {31'd0, s_last[0]}, {31'd0, tab[i].el});
      chk($sformatf("tab_in_ready c%0d", i),  {31'd0, s_rdy[0]},  {31'd0, tab[i].er});
      chk($sformatf("tab_busy c%0d", i),      {31'd0, s_busy[0]}, {31'd0, tab[i].ey});
    end

    // ---------------- Back-to-back A5 then 3C ----------------
    bb = 16'hA53C;
    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    tick();
    drive(1'b0, 1'b1, 1'b1, 8'h3C);
    tick();
    chk("b2b_valid c1", {31'd0, s_val[0]}, 32'd1);
    chk("b2b_bit c1",   {31'd0, s_bit[0]}, {31'd0, bb[15]});
    chk("b2b_ready c1", {31'd0, s_rdy[0]}, 32'd1);
    for (int c = 2; c <= 17; c++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      tick();
      if (c <= 16) begin
        chk($sformatf("b2b_valid c%0d", c), {31'd0, s_val[0]}, 32'd1);
        chk($sformatf("b2b_bit c%0d", c),   {31'd0, s_bit[0]}, {31'd0, bb[16-c]});
        chk($sformatf("b2b_ready c%0d", c), {31'd0, s_rdy[0]}, (c <= 8) ? 32'd0 : 32'd1);
        chk($sformatf("b2b_last c%0d", c),  {31'd0, s_last[0]},
            (c == 8 || c == 16) ? 32'd1 : 32'd0);
      end else begin
        chk("b2b_valid_end", {31'd0, s_val[0]},  32'd0);
        chk("b2b_busy_end",  {31'd0, s_busy[0]}, 32'd0);
      end
    end

    // ---------------- LSB first: 8'h01 ----------------
    drive(1'b0, 1'b1, 1'b1, 8'h01);
    tick();
    for (int c = 1; c <= 9; c++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      tick();
      chk($sformatf("lsb_bit c%0d", c),   {31'd0, s_bit[1]}, (c == 1) ? 32'd1 : 32'd0);
      chk($sformatf("lsb_valid c%0d", c), {31'd0, s_val[1]}, (c <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("msb_of01_bit c%0d", c), {31'd0, s_bit[0]}, (c == 8) ? 32'd1 : 32'd0);
    end

    // ---------------- Enable stall on 8'hF0 ----------------
    f0_bits = 8'hF0;
    nval = 0; lastc = -1; j = 0;
    drive(1'b0, 1'b1, 1'b1, 8'hF0);
    tick();
    for (int c = 1; c <= 13; c++) begin
      en = !(c >= 3 && c <= 5);
      drive(1'b0, en, 1'b0, '0);
      tick();
      if (!en) begin
        chk($sformatf("stall_valid c%0d", c), {31'd0, s_val[0]}, 32'd0);
        chk($sformatf("stall_bit c%0d", c),   {31'd0, s_bit[0]}, 32'd0);
      end
      if (s_val[0] && j < 8) begin
        chk($sformatf("stall_data c%0d", c), {31'd0, s_bit[0]}, {31'd0, f0_bits[7-j]});
        j++;
      end
      if (s_val[0]) nval++;
      if (s_last[0]) lastc = c;
    end
    chk("stall_valid_count", nval, 32'd8);
    chk("stall_last_cycle",  lastc, 32'd11);

    // ---------------- Reset mid-word ----------------
    w81 = 8'h81;
    drive(1'b0, 1'b1, 1'b1, 8'hFF);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    chk("rstmid_ready_c4", {31'd0, s_rdy[0]}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 8'h81);
    tick();
    chk("rstmid_valid_c5", {31'd0, s_val[0]},  32'd0);
    chk("rstmid_busy_c5",  {31'd0, s_busy[0]}, 32'd0);
    chk("rstmid_bit_c5",   {31'd0, s_bit[0]},  32'd0);
    chk("rstmid_ready_c5", {31'd0, s_rdy[0]},  32'd1);
    for (int c = 6; c <= 14; c++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      tick();
      if (c <= 13) begin
        chk($sformatf("rstmid_81_bit c%0d", c),   {31'd0, s_bit[0]}, {31'd0, w81[13-c]});
        chk($sformatf("rstmid_81_valid c%0d", c), {31'd0, s_val[0]}, 32'd1);
      end else begin
        chk("rstmid_81_done", {31'd0, s_busy[0]}, 32'd0);
      end
    end

    // ---------------- Chained with the detector ----------------
    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 8'b1010_0000);
    tick();
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      tick();
      if (s_det) pulses++;
      if (c == 4) chk("det_pulse_c4", {31'd0, s_det}, 32'd1);
    end
    chk("det_pulse_count", pulses, 32'd1);

    // ---------------- Randomised traffic against the model ----------------
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), W'($urandom));
      tick();
    end

    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
